// File: rtl/shift_arbiter.sv
// Two-requester round-robin arbiter feeding a multi-pass barrel shifter.
// Each accepted job is shifted at most 7 bits per cycle, then held until the consumer takes it.
module shift_arbiter #(
  parameter int DATA_WIDTH  = 8,
  parameter int SHAMT_WIDTH = 5
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   req0_valid,
  output logic                   req0_ready,
  input  logic [DATA_WIDTH-1:0]  req0_data,
  input  logic [SHAMT_WIDTH-1:0] req0_shamt,
  input  logic                   req0_lr,
  input  logic                   req0_al,
  input  logic                   req1_valid,
  output logic                   req1_ready,
  input  logic [DATA_WIDTH-1:0]  req1_data,
  input  logic [SHAMT_WIDTH-1:0] req1_shamt,
  input  logic                   req1_lr,
  input  logic                   req1_al,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic [DATA_WIDTH-1:0]  out_data,
  output logic                   out_id,
  output logic                   busy,
  output logic [7:0]             done_cnt
);

  typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;

  localparam logic [SHAMT_WIDTH-1:0] MAX_STEP = SHAMT_WIDTH'(7);

  state_t                 state_q;
  logic [DATA_WIDTH-1:0]  acc_q, acc_d;
  logic [SHAMT_WIDTH-1:0] rem_q, rem_d, step;
  logic                   lr_q, al_q, id_q, ptr_q;
  logic                   out_valid_q, out_id_q, busy_q;
  logic [DATA_WIDTH-1:0]  out_data_q;
  logic [7:0]             done_cnt_q;

  logic                   in_idle, grant0, grant1, accept;
  logic [DATA_WIDTH-1:0]  data_sel;
  logic [SHAMT_WIDTH-1:0] shamt_sel;
  logic                   lr_sel, al_sel;

  // Single pass of at most 7 bits; arithmetic fill replicates the edge bit of the current value.
  function automatic logic [DATA_WIDTH-1:0] shift3(
    input logic [DATA_WIDTH-1:0] d,
    input logic [2:0]            s,
    input logic                  lr,
    input logic                  al
  );
    logic [DATA_WIDTH-1:0] ones;
    logic [DATA_WIDTH-1:0] res;
    ones = '1;
    if (lr) begin
      res = (d >> s) | (~(ones >> s) & {DATA_WIDTH{al & d[DATA_WIDTH-1]}});
    end else begin
      res = (d << s) | (~(ones << s) & {DATA_WIDTH{al & d[0]}});
    end
    return res;
  endfunction

  assign in_idle = rst_n && (state_q == IDLE);
  assign grant0  = in_idle && req0_valid && (!req1_valid || !ptr_q);
  assign grant1  = in_idle && req1_valid && (!req0_valid ||  ptr_q);
  assign accept  = grant0 || grant1;

  assign req0_ready = grant0;
  assign req1_ready = grant1;

  always_comb begin
    data_sel  = req0_data;
    shamt_sel = req0_shamt;
    lr_sel    = req0_lr;
    al_sel    = req0_al;
    if (grant1) begin
      data_sel  = req1_data;
      shamt_sel = req1_shamt;
      lr_sel    = req1_lr;
      al_sel    = req1_al;
    end
  end

  always_comb begin
    step  = (rem_q > MAX_STEP) ? MAX_STEP : rem_q;
    acc_d = shift3(acc_q, step[2:0], lr_q, al_q);
    rem_d = rem_q - step;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      acc_q       <= '0;
      rem_q       <= '0;
      lr_q        <= 1'b0;
      al_q        <= 1'b0;
      id_q        <= 1'b0;
      ptr_q       <= 1'b0;
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
      out_id_q    <= 1'b0;
      busy_q      <= 1'b0;
      done_cnt_q  <= '0;
    end else begin
      case (state_q)
        IDLE: begin
          if (accept) begin
            acc_q   <= data_sel;
            rem_q   <= shamt_sel;
            lr_q    <= lr_sel;
            al_q    <= al_sel;
            id_q    <= grant1;
            ptr_q   <= ~grant1;
            busy_q  <= 1'b1;
            state_q <= SHIFT;
          end
        end
        SHIFT: begin
          acc_q <= acc_d;
          rem_q <= rem_d;
          // The result register only loads here, so out_data holds between jobs.
          if (rem_d == '0) begin
            state_q     <= DONE;
            out_valid_q <= 1'b1;
            out_data_q  <= acc_d;
            out_id_q    <= id_q;
          end
        end
        DONE: begin
          if (out_ready) begin
            state_q     <= IDLE;
            out_valid_q <= 1'b0;
            busy_q      <= 1'b0;
            done_cnt_q  <= done_cnt_q + 8'd1;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign out_valid = out_valid_q;
  assign out_data  = out_data_q;
  assign out_id    = out_id_q;
  assign busy      = busy_q;
  assign done_cnt  = done_cnt_q;

endmodule

// File: tb/tb_shift_arbiter.sv
// Directed bench for shift_arbiter with a cycle-level reference model and per-cycle output compare.
module tb_shift_arbiter;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       req0_valid, req0_ready, req0_lr, req0_al;
  logic [7:0] req0_data;
  logic [4:0] req0_shamt;
  logic       req1_valid, req1_ready, req1_lr, req1_al;
  logic [7:0] req1_data;
  logic [4:0] req1_shamt;
  logic       out_valid, out_ready, out_id, busy;
  logic [7:0] out_data, done_cnt;

  int unsigned vectors    = 0;
  int unsigned miscompares = 0;

  always #5 clk = ~clk;

  shift_arbiter #(.DATA_WIDTH(8), .SHAMT_WIDTH(5)) dut (
    .clk(clk), .rst_n(rst_n),
    .req0_valid(req0_valid), .req0_ready(req0_ready), .req0_data(req0_data),
    .req0_shamt(req0_shamt), .req0_lr(req0_lr), .req0_al(req0_al),
    .req1_valid(req1_valid), .req1_ready(req1_ready), .req1_data(req1_data),
    .req1_shamt(req1_shamt), .req1_lr(req1_lr), .req1_al(req1_al),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
    .out_id(out_id), .busy(busy), .done_cnt(done_cnt)
  );

  task automatic check8(input string name, input logic [7:0] act, input logic [7:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got 0x%02h expected 0x%02h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference: shamt repeated single-bit shifts.
  function automatic logic [7:0] ref_shift(input logic [7:0] d, input int n, input bit lr, input bit al);
    for (int i = 0; i < n; i++) begin
      if (lr) d = {al & d[7], d[7:1]};
      else    d = {d[6:0], al & d[0]};
    end
    return d;
  endfunction

  // Model state
  bit         m_init = 0;
  bit         m_busy, m_valid, m_id, m_pid, m_ptr;
  logic [7:0] m_data, m_pend, m_cnt;
  int         m_left;
  int         grants[$];

  function automatic bit exp_ready(input int n);
    if (!rst_n || m_busy) return 1'b0;
    if (n == 0) return req0_valid && (!req1_valid || !m_ptr);
    return req1_valid && (!req0_valid || m_ptr);
  endfunction

  always @(posedge clk) begin : model
    bit g0, g1;
    int sh;
    g0 = exp_ready(0);
    g1 = exp_ready(1);
    if (!rst_n) begin
      m_init = 1; m_busy = 0; m_valid = 0; m_id = 0; m_pid = 0; m_ptr = 0;
      m_data = 8'h00; m_pend = 8'h00; m_cnt = 8'h00; m_left = 0;
    end else if (!m_busy) begin
      if (g0 || g1) begin
        sh     = g1 ? int'(req1_shamt) : int'(req0_shamt);
        m_pend = g1 ? ref_shift(req1_data, sh, req1_lr, req1_al)
                    : ref_shift(req0_data, sh, req0_lr, req0_al);
        m_left = (sh == 0) ? 1 : (sh + 6) / 7;
        m_pid  = g1;
        m_ptr  = !g1;
        m_busy = 1;
      end
    end else if (m_left > 0) begin
      m_left--;
      if (m_left == 0) begin
        m_valid = 1; m_data = m_pend; m_id = m_pid;
      end
    end else if (out_ready) begin
      m_valid = 0; m_busy = 0; m_cnt = m_cnt + 8'd1;
    end
  end

  always @(negedge clk) begin
    if (m_init) begin
      check8("req0_ready", {7'd0, req0_ready}, {7'd0, exp_ready(0)});
      check8("req1_ready", {7'd0, req1_ready}, {7'd0, exp_ready(1)});
      check8("busy",       {7'd0, busy},       {7'd0, m_busy});
      check8("out_valid",  {7'd0, out_valid},  {7'd0, m_valid});
      check8("out_data",   out_data,           m_data);
      check8("out_id",     {7'd0, out_id},     {7'd0, m_id});
      check8("done_cnt",   done_cnt,           m_cnt);
      if (rst_n && req0_ready) grants.push_back(0);
      if (rst_n && req1_ready) grants.push_back(1);
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_job(input bit id, input logic [7:0] d, input logic [4:0] sh, input bit lr,
                        input bit al, input logic [7:0] exp_d, input int exp_cyc, input int hold);
    int n;
    check8("ref_model", ref_shift(d, int'(sh), lr, al), exp_d);
    if (id) begin
      req1_valid = 1; req1_data = d; req1_shamt = sh; req1_lr = lr; req1_al = al;
    end else begin
      req0_valid = 1; req0_data = d; req0_shamt = sh; req0_lr = lr; req0_al = al;
    end
    tick();
    req0_valid = 0; req1_valid = 0;
    n = 0;
    while (!out_valid && n < 64) begin
      tick();
      n++;
    end
    check8("shift_cycles", 8'(n), 8'(exp_cyc));
    check8("job_data", out_data, exp_d);
    check8("job_id", {7'd0, out_id}, {7'd0, id});
    for (int i = 0; i < hold; i++) begin
      req0_valid = 1; req1_valid = 1;
      tick();
      check8("hold_data", out_data, exp_d);
      check8("hold_valid", {7'd0, out_valid}, 8'd1);
    end
    out_ready = 1;
    tick();
    out_ready = 0; req0_valid = 0; req1_valid = 0;
    check8("post_hs_busy", {7'd0, busy}, 8'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    rst_n = 0; out_ready = 0;
    req0_valid = 0; req0_data = 8'h00; req0_shamt = 5'd0; req0_lr = 0; req0_al = 0;
    req1_valid = 0; req1_data = 8'h00; req1_shamt = 5'd0; req1_lr = 0; req1_al = 0;

    // Both requesters valid continuously from reset: alternating grants.
    req0_valid = 1; req0_data = 8'h11; req0_shamt = 5'd1; req0_lr = 0; req0_al = 0;
    req1_valid = 1; req1_data = 8'h22; req1_shamt = 5'd1; req1_lr = 1; req1_al = 0;
    out_ready  = 1;
    repeat (3) tick();
    grants.delete();
    rst_n = 1;
    n = 0;
    while (done_cnt != 8'd4 && n < 100) begin
      tick();
      n++;
    end
    req0_valid = 0; req1_valid = 0; out_ready = 0;
    check8("rr_done_cnt", done_cnt, 8'd4);
    check8("rr_grant_count", 8'(grants.size()), 8'd4);
    if (grants.size() >= 4) begin
      check8("rr_grant0", 8'(grants[0]), 8'd0);
      check8("rr_grant1", 8'(grants[1]), 8'd1);
      check8("rr_grant2", 8'(grants[2]), 8'd0);
      check8("rr_grant3", 8'(grants[3]), 8'd1);
    end

    // Reset values
    rst_n = 0;
    repeat (2) tick();
    check8("rst_done_cnt", done_cnt, 8'h00);
    check8("rst_out_valid", {7'd0, out_valid}, 8'd0);
    check8("rst_out_data", out_data, 8'h00);
    check8("rst_out_id", {7'd0, out_id}, 8'd0);
    check8("rst_busy", {7'd0, busy}, 8'd0);
    rst_n = 1;
    tick();

    // Reset during the second SHIFT cycle of a 31-bit job
    req0_valid = 1; req0_data = 8'hAA; req0_shamt = 5'd31; req0_lr = 1; req0_al = 1;
    tick();
    req0_valid = 0;
    tick();
    check8("midshift_busy", {7'd0, busy}, 8'd1);
    rst_n = 0;
    tick();
    rst_n = 1;
    check8("abort_busy", {7'd0, busy}, 8'd0);
    check8("abort_out_valid", {7'd0, out_valid}, 8'd0);
    check8("abort_done_cnt", done_cnt, 8'h00);
    req0_valid = 1; req1_valid = 1;
    #1;
    check8("abort_ptr_r0", {7'd0, req0_ready}, 8'd1);
    check8("abort_ptr_r1", {7'd0, req1_ready}, 8'd0);
    req0_valid = 0; req1_valid = 0;
    tick();

    do_job(0, 8'h96, 5'd3,  1, 1, 8'hF2, 1, 0);
    do_job(1, 8'h81, 5'd20, 0, 0, 8'h00, 3, 0);
    do_job(0, 8'h05, 5'd9,  0, 1, 8'hFF, 2, 0);
    do_job(0, 8'h3C, 5'd0,  0, 0, 8'h3C, 1, 0);
    do_job(1, 8'hF0, 5'd4,  1, 0, 8'h0F, 1, 5);
    do_job(0, 8'h80, 5'd31, 1, 1, 8'hFF, 5, 0);
    do_job(1, 8'h7E, 5'd8,  0, 1, 8'h00, 2, 0);
    do_job(1, 8'h01, 5'd3,  0, 1, 8'h0F, 1, 0);
    tick();
    check8("final_done_cnt", done_cnt, 8'd8);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
